// File: rtl/key_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module : key_led_ctrl
// Brief  : Debounced single key -> short/long press events -> 4-mode LED driver
// Rev    : 1.0  initial release
// ============================================================================

module key_led_ctrl #(
   parameter int DEB_CYC  = 1000000,
   parameter int LONG_CYC = 50000000,
   parameter int STEP_CYC = 12500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_in,
   output logic [3:0] led,
   output logic [1:0] mode,
   output logic       key_stable,
   output logic       short_press,
   output logic       long_press
);

   localparam int c_DEB_W  = $clog2(DEB_CYC);
   localparam int c_HOLD_W = $clog2(LONG_CYC + 1);
   localparam int c_STEP_W = $clog2(STEP_CYC);

   localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_CYC - 1);
   localparam logic [c_DEB_W-1:0]  c_DEB_ONE   = c_DEB_W'(1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(LONG_CYC);
   localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
   localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_CYC - 1);
   localparam logic [c_STEP_W-1:0] c_STEP_ONE  = c_STEP_W'(1);

   generate
      if (DEB_CYC < 2 || LONG_CYC < 2 || STEP_CYC < 2) begin : g_param_check
         $error("key_led_ctrl: DEB_CYC, LONG_CYC and STEP_CYC must all be >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_STATIC = 2'd1,
      MODE_SHIFT  = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_t;

   logic                r_sync1;
   logic                r_sync2;
   logic [c_DEB_W-1:0]  r_deb_cnt;
   logic                r_key_stable;
   logic                r_key_prev;
   logic [c_HOLD_W-1:0] r_hold_cnt;
   logic                r_long_done;
   logic                r_short;
   logic                r_long;
   mode_t               r_mode;
   logic                r_mode_chg;
   logic [c_STEP_W-1:0] r_step_cnt;
   logic [3:0]          r_led;

   logic                w_rise;
   logic                w_fall;
   logic                w_hold_full;
   logic                w_long_hit;
   mode_t               w_mode_nxt;
   logic                w_mode_upd;
   logic                w_tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= key_in;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_deb_cnt    <= '0;
         r_key_stable <= 1'b0;
      end else if (r_sync2 == r_key_stable) begin
         r_deb_cnt <= '0;
      end else if (r_deb_cnt == c_DEB_LAST) begin
         r_deb_cnt    <= '0;
         r_key_stable <= ~r_key_stable;
      end else begin
         r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
      end
   end

   assign w_rise      = r_key_stable & ~r_key_prev;
   assign w_fall      = ~r_key_stable & r_key_prev;
   assign w_hold_full = (r_hold_cnt == c_HOLD_MAX);
   // Only fire while still held, so a release never coincides with a long event
   assign w_long_hit  = r_key_stable & w_hold_full & ~r_long_done & ~w_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_prev  <= 1'b0;
         r_hold_cnt  <= '0;
         r_long_done <= 1'b0;
         r_short     <= 1'b0;
         r_long      <= 1'b0;
      end else begin
         r_key_prev <= r_key_stable;
         r_short    <= w_fall & ~r_long_done;
         r_long     <= w_long_hit;
         if (w_rise) begin
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
         end else begin
            if (r_key_stable && !w_hold_full) begin
               r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
            end
            if (w_long_hit) begin
               r_long_done <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_mode_nxt = r_mode;
      if (r_long) begin
         w_mode_nxt = MODE_OFF;
      end else if (r_short) begin
         w_mode_nxt = mode_t'(r_mode + 2'd1);
      end
   end

   assign w_mode_upd = (w_mode_nxt != r_mode);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode     <= MODE_OFF;
         r_mode_chg <= 1'b0;
      end else begin
         r_mode     <= w_mode_nxt;
         r_mode_chg <= w_mode_upd;
      end
   end

   // Timer restarts again with the LED load so the first pattern lasts a full step
   assign w_tick = (r_step_cnt == c_STEP_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step_cnt <= '0;
      end else if (w_mode_upd || r_mode_chg || w_tick) begin
         r_step_cnt <= '0;
      end else begin
         r_step_cnt <= r_step_cnt + c_STEP_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_led <= 4'b0000;
      end else if (r_mode_chg) begin
         case (r_mode)
            MODE_OFF:    r_led <= 4'b0000;
            MODE_STATIC: r_led <= 4'b1111;
            MODE_SHIFT:  r_led <= 4'b0001;
            default:     r_led <= 4'b1111;
         endcase
      end else if (w_tick) begin
         case (r_mode)
            MODE_SHIFT: r_led <= {r_led[2:0], r_led[3]};
            MODE_BLINK: r_led <= ~r_led;
            default:    r_led <= r_led;
         endcase
      end
   end

   assign led         = r_led;
   assign mode        = r_mode;
   assign key_stable  = r_key_stable;
   assign short_press = r_short;
   assign long_press  = r_long;

endmodule

`default_nettype wire

// File: tb/tb_key_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_key_led_ctrl
// Brief  : Self-checking bench for key_led_ctrl (DEB=4, LONG=20, STEP=3)
// Rev    : 1.0  initial release
// ============================================================================

module tb_key_led_ctrl;

   localparam int DEB  = 4;
   localparam int LONG = 20;
   localparam int STEP = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_in = 1'b0;
   logic [3:0] led;
   logic [1:0] mode;
   logic       key_stable;
   logic       short_press;
   logic       long_press;

   key_led_ctrl #(
      .DEB_CYC  (DEB),
      .LONG_CYC (LONG),
      .STEP_CYC (STEP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in),
      .led         (led),
      .mode        (mode),
      .key_stable  (key_stable),
      .short_press (short_press),
      .long_press  (long_press)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_long;
      logic [1:0] nmode;
   } ev_t;

   typedef struct {
      int         hold;
      bit         exp_pulse;
      bit         is_long;
      logic [1:0] mode_after;
   } vec_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic logic [3:0] led_init(input logic [1:0] m);
      case (m)
         2'd0:    return 4'b0000;
         2'd1:    return 4'b1111;
         2'd2:    return 4'b0001;
         default: return 4'b1111;
      endcase
   endfunction

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_ev(input bit is_long, input logic [1:0] nmode);
      ev_t e;
      e.is_long = is_long;
      e.nmode   = nmode;
      exp_q.push_back(e);
   endtask

   task automatic press(input int hold, input int settle, output bit saw);
      saw = 1'b0;
      key_in = 1'b1;
      for (int i = 0; i < hold; i++) begin
         step(1);
         saw |= key_stable;
      end
      key_in = 1'b0;
      for (int i = 0; i < settle; i++) begin
         step(1);
         saw |= key_stable;
      end
   endtask

   task automatic wait_mode(input logic [1:0] m, input string name);
      int n = 0;
      while (mode != m && n < 60) begin
         step(1);
         n++;
      end
      check(name, int'(mode), int'(m));
   endtask

   // Pulse scoreboard: every pulse must match the queue head, then mode and led follow
   initial begin
      int         mode_wait = 0;
      logic [1:0] want_mode = 2'd0;
      ev_t        e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mode_wait = 0;
         end else begin
            if (mode_wait == 2) begin
               check("mode_after_pulse", int'(mode), int'(want_mode));
               mode_wait = 1;
            end else if (mode_wait == 1) begin
               check("led_after_mode", int'(led), int'(led_init(want_mode)));
               mode_wait = 0;
            end
            if (short_press || long_press) begin
               check("pulse_exclusive", int'(short_press & long_press), 0);
               if (exp_q.size() == 0) begin
                  check("spurious_pulse", int'({short_press, long_press}), 0);
               end else begin
                  e = exp_q.pop_front();
                  check("pulse_kind_long", int'(long_press), int'(e.is_long));
                  want_mode = e.nmode;
                  mode_wait = 2;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time=%0t limit=%0d", $time, 200000);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t       vecs[9];
      bit         saw;
      logic [3:0] shift_pat[5];
      logic [3:0] blink_pat[3];

      vecs[0] = '{hold: 1,  exp_pulse: 1'b0, is_long: 1'b0, mode_after: 2'd1};
      vecs[1] = '{hold: 2,  exp_pulse: 1'b0, is_long: 1'b0, mode_after: 2'd1};
      vecs[2] = '{hold: 3,  exp_pulse: 1'b0, is_long: 1'b0, mode_after: 2'd1};
      vecs[3] = '{hold: 4,  exp_pulse: 1'b1, is_long: 1'b0, mode_after: 2'd2};
      vecs[4] = '{hold: 12, exp_pulse: 1'b1, is_long: 1'b0, mode_after: 2'd3};
      vecs[5] = '{hold: 16, exp_pulse: 1'b1, is_long: 1'b0, mode_after: 2'd0};
      vecs[6] = '{hold: 26, exp_pulse: 1'b1, is_long: 1'b1, mode_after: 2'd0};
      vecs[7] = '{hold: 12, exp_pulse: 1'b1, is_long: 1'b0, mode_after: 2'd1};
      vecs[8] = '{hold: 40, exp_pulse: 1'b1, is_long: 1'b1, mode_after: 2'd0};

      shift_pat[0] = 4'b0001;
      shift_pat[1] = 4'b0010;
      shift_pat[2] = 4'b0100;
      shift_pat[3] = 4'b1000;
      shift_pat[4] = 4'b0001;
      blink_pat[0] = 4'b1111;
      blink_pat[1] = 4'b0000;
      blink_pat[2] = 4'b1111;

      // Reset state
      step(3);
      check("reset_outputs", int'({led, mode, key_stable, short_press, long_press}), 0);
      rst_n = 1'b1;
      step(2);

      // Debounce latency (2 sync + DEB cycles) on a 12-cycle press
      expect_ev(1'b0, 2'd1);
      key_in = 1'b1;
      step(5);
      check("deb_latency_early", int'(key_stable), 0);
      step(1);
      check("deb_latency_exact", int'(key_stable), 1);
      step(6);
      key_in = 1'b0;
      step(16);
      check("first_short_queue", exp_q.size(), 0);
      check("first_short_mode", int'(mode), 1);
      check("first_short_led", int'(led), 4'b1111);

      // Table: bounces, boundary press, wrap and long presses
      for (int v = 0; v < 9; v++) begin
         if (vecs[v].exp_pulse) expect_ev(vecs[v].is_long, vecs[v].mode_after);
         press(vecs[v].hold, 16, saw);
         check($sformatf("v%0d_key_seen", v), int'(saw), int'(vecs[v].exp_pulse));
         check($sformatf("v%0d_pulse_missing", v), exp_q.size(), 0);
         check($sformatf("v%0d_mode", v), int'(mode), int'(vecs[v].mode_after));
      end
      check("wrap_end_led", int'(led), 0);

      // SHIFT animation, each pattern held STEP cycles
      expect_ev(1'b0, 2'd1);
      press(12, 16, saw);
      expect_ev(1'b0, 2'd2);
      key_in = 1'b1;
      step(12);
      key_in = 1'b0;
      wait_mode(2'd2, "shift_reached");
      for (int i = 0; i < 15; i++) begin
         step(1);
         check($sformatf("shift_led%0d", i), int'(led), int'(shift_pat[i / 3]));
      end

      // BLINK animation
      expect_ev(1'b0, 2'd3);
      key_in = 1'b1;
      step(12);
      key_in = 1'b0;
      wait_mode(2'd3, "blink_reached");
      for (int i = 0; i < 9; i++) begin
         step(1);
         check($sformatf("blink_led%0d", i), int'(led), int'(blink_pat[i / 3]));
      end

      // Long press in BLINK: one long event, back to OFF, no short on release
      expect_ev(1'b1, 2'd0);
      press(40, 20, saw);
      check("blink_long_queue", exp_q.size(), 0);
      check("blink_long_mode", int'(mode), 0);
      check("blink_long_led", int'(led), 0);

      // Asynchronous reset mid-press, key still held across release
      expect_ev(1'b0, 2'd1);
      press(12, 16, saw);
      check("pre_reset_led", int'(led), 4'b1111);
      key_in = 1'b1;
      step(10);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", int'({led, mode, key_stable, short_press, long_press}), 0);
      step(3);
      rst_n = 1'b1;
      expect_ev(1'b0, 2'd1);
      step(5);
      check("held_after_reset_early", int'(key_stable), 0);
      step(1);
      check("held_after_reset_seen", int'(key_stable), 1);
      step(6);
      key_in = 1'b0;
      step(16);
      check("held_after_reset_queue", exp_q.size(), 0);
      check("held_after_reset_mode", int'(mode), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
